// File: rtl/irda_in.sv
// irda_in: IR serial receiver paired with the fishbowl IR transmitter.
// Frame on the idle-low line: start bit 1, DW data bits LSB first, stop bit 0,
// each bit DIV clk cycles long. Good frames update Dout with a one-cycle
// Dout_vld pulse; a bad stop bit gives a one-cycle frm_err pulse instead.
// Optional build macro IRDA_MAJ_VOTE_EN: every bit decision becomes a 2-of-3
// majority of s around the nominal sample point, decided one cycle later.
module irda_in #(
  parameter int DIV = 50,
  parameter int DW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Iin,
  output logic [DW-1:0] Dout,
  output logic          Dout_vld,
  output logic          frm_err,
  output logic          busy
);

  localparam int CW = $clog2(DIV);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [CW-1:0] BIT_END   = CW'(DIV - 1);
`ifdef IRDA_MAJ_VOTE_EN
  // The start decision moves one cycle later so the third vote (M+1) exists;
  // data and stop points are relative to it and shift along automatically.
  localparam logic [CW-1:0] START_END = CW'(DIV / 2);
`else
  localparam logic [CW-1:0] START_END = CW'(DIV / 2 - 1);
`endif
  localparam logic [BW-1:0] LAST_BIT  = BW'(DW - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt0_q, cnt0_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            vld_q, vld_d;
  logic            err_q, err_d;

  logic            sync1_q;
  logic            s_q;
  logic            sd_q;
  logic            rise;
  logic            bitVal;

`ifdef IRDA_MAJ_VOTE_EN
  logic            sdd_q;

  // Extra history flop so s at M-1, M and M+1 are all visible at M+1.
  always_ff @(posedge clk) begin
    if (rst) sdd_q <= 1'b0;
    else     sdd_q <= sd_q;
  end

  assign bitVal = (s_q & sd_q) | (s_q & sdd_q) | (sd_q & sdd_q);
`else
  assign bitVal = s_q;
`endif

  // Two-flop synchronizer for the asynchronous line plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      sync1_q <= Iin;
      s_q     <= sync1_q;
      sd_q    <= s_q;
    end
  end

  assign rise = s_q & ~sd_q;

  // State, counters, shift register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt0_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // Frame sequencing: a start edge is qualified at mid start bit, then every
  // later bit is sampled DIV cycles after the previous sample (mid-bit).
  always_comb begin
    state_d = state_q;
    cnt0_d  = cnt0_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = START;
          cnt0_d  = '0;
        end
      end
      START: begin
        if (cnt0_q == START_END) begin
          cnt0_d = '0;
          if (bitVal) begin
            state_d = DATA;
            bcnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt0_d = cnt0_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt0_q == BIT_END) begin
          shreg_d[bcnt_q] = bitVal;
          cnt0_d          = '0;
          if (bcnt_q == LAST_BIT) state_d = STOP;
          else                    bcnt_d  = bcnt_q + 1'b1;
        end else begin
          cnt0_d = cnt0_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt0_q == BIT_END) begin
          cnt0_d  = '0;
          state_d = IDLE;
          if (!bitVal) begin
            dout_d = shreg_q;
            vld_d  = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end else begin
          cnt0_d = cnt0_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Dout     = dout_q;
  assign Dout_vld = vld_q;
  assign frm_err  = err_q;
  assign busy     = (state_q != IDLE);

endmodule
